// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: streams one block of word reads to a pipelined memory and writes the returns into the cache.
// Optional macro CACHE_FILL_CRITICAL_WORD_FIRST_EN: fill starts at the missed word and wraps within the block.
module cache_fill_fsm #(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               miss_detected,
    input  logic [ADDR_WIDTH-1:0]              miss_address,
    input  logic                               memory_data_valid,
    input  logic [15:0]                        memory_data,
    output logic                               memory_enable,
    output logic [ADDR_WIDTH-1:0]              memory_address,
    output logic                               fsm_busy,
    output logic                               write_data_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] cache_word_index,
    output logic [15:0]                        cache_data,
    output logic                               write_tag_array,
    output logic                               fill_done
);
    localparam int WORD_BITS = $clog2(WORDS_PER_BLOCK);
    localparam int OFF_BITS  = WORD_BITS + 1;
    localparam int CNT_BITS  = WORD_BITS + 1;
    localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = ~ADDR_WIDTH'((2 * WORDS_PER_BLOCK) - 1);
    localparam logic [CNT_BITS-1:0]   LAST_IDX   = CNT_BITS'(WORDS_PER_BLOCK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                r_state;
    logic [CNT_BITS-1:0]   r_req_cnt;
    logic [CNT_BITS-1:0]   r_ret_cnt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [MEM_LATENCY-1:0] r_req_pipe;

    logic                  w_fill;
    logic                  w_req_active;
    logic                  w_ret_fire;
    logic                  w_last_ret;
    logic [WORD_BITS-1:0]  w_req_word;
    logic [WORD_BITS-1:0]  w_ret_word;
    logic [ADDR_WIDTH-1:0] w_req_addr;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    logic [WORD_BITS-1:0]  r_miss_word;

    // Word slots rotate from the missed word; the sum wraps inside the block by width.
    assign w_req_word = r_req_cnt[WORD_BITS-1:0] + r_miss_word;
    assign w_ret_word = r_ret_cnt[WORD_BITS-1:0] + r_miss_word;
`else
    assign w_req_word = r_req_cnt[WORD_BITS-1:0];
    assign w_ret_word = r_ret_cnt[WORD_BITS-1:0];
`endif

    assign w_fill       = (r_state == FILL);
    // The request counter stops at WORDS_PER_BLOCK, so its top bit marks "all issued".
    assign w_req_active = w_fill && !r_req_cnt[CNT_BITS-1];
    assign w_ret_fire   = w_fill && memory_data_valid;
    assign w_last_ret   = w_ret_fire && (r_ret_cnt == LAST_IDX);
    assign w_req_addr   = r_base + {{(ADDR_WIDTH - OFF_BITS){1'b0}}, w_req_word, 1'b0};

    assign memory_enable    = w_req_active;
    assign memory_address   = w_req_active ? w_req_addr : '0;
    assign fsm_busy         = w_fill;
    assign write_data_array = w_ret_fire;
    assign cache_word_index = w_ret_fire ? w_ret_word : '0;
    assign cache_data       = w_ret_fire ? memory_data : '0;
    assign write_tag_array  = w_last_ret;
    assign fill_done        = w_last_ret;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_req_cnt <= '0;
            r_ret_cnt <= '0;
            r_base    <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
            r_miss_word <= '0;
`endif
        end else if (r_state == IDLE) begin
            if (miss_detected) begin
                r_base    <= miss_address & BLOCK_MASK;
                r_req_cnt <= '0;
                r_ret_cnt <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
                r_miss_word <= miss_address[OFF_BITS-1:1];
`endif
                r_state   <= FILL;
            end
        end else begin
            if (w_req_active) begin
                r_req_cnt <= r_req_cnt + 1'b1;
            end
            if (w_ret_fire) begin
                r_ret_cnt <= r_ret_cnt + 1'b1;
            end
            if (w_last_ret) begin
                r_state <= IDLE;
            end
        end
    end

    // Request history used only to check that returns arrive MEM_LATENCY cycles after a request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_pipe <= '0;
        end else begin
            r_req_pipe <= MEM_LATENCY'({r_req_pipe, memory_enable});
        end
    end

    a_return_latency: assert property (@(posedge clk) disable iff (!rst)
        (fsm_busy && memory_data_valid) |-> r_req_pipe[MEM_LATENCY-1]);

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a 4-cycle pipelined memory model; honours CACHE_FILL_CRITICAL_WORD_FIRST_EN.
module tb_cache_fill_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        memory_enable;
    logic [15:0] memory_address;
    logic        fsm_busy;
    logic        write_data_array;
    logic [2:0]  cache_word_index;
    logic [15:0] cache_data;
    logic        write_tag_array;
    logic        fill_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] obs_addr [8];
    logic [2:0]  obs_idx  [8];

    // Injected return used to poke the DUT while it is idle.
    logic        inj_valid = 1'b0;
    logic [15:0] inj_data  = '0;

    logic [2:0]  mdl_v;
    logic [15:0] mdl_a [3];
    logic        mdl_valid;
    logic [15:0] mdl_data;

    always #5 clk = ~clk;

    cache_fill_fsm #(
        .ADDR_WIDTH(16),
        .WORDS_PER_BLOCK(8),
        .MEM_LATENCY(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .miss_detected(miss_detected),
        .miss_address(miss_address),
        .memory_data_valid(memory_data_valid),
        .memory_data(memory_data),
        .memory_enable(memory_enable),
        .memory_address(memory_address),
        .fsm_busy(fsm_busy),
        .write_data_array(write_data_array),
        .cache_word_index(cache_word_index),
        .cache_data(cache_data),
        .write_tag_array(write_tag_array),
        .fill_done(fill_done)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C96;
    endfunction

    // Memory: request sampled at edge k, data valid from edge k+3 (four cycles after the request cycle).
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdl_v     <= '0;
            mdl_valid <= 1'b0;
            mdl_data  <= '0;
        end else begin
            mdl_v     <= {mdl_v[1:0], memory_enable};
            mdl_a[0]  <= memory_address;
            mdl_a[1]  <= mdl_a[0];
            mdl_a[2]  <= mdl_a[1];
            mdl_valid <= mdl_v[2];
            mdl_data  <= mem_word(mdl_a[2]);
        end
    end

    assign memory_data_valid = mdl_valid | inj_valid;
    assign memory_data       = inj_valid ? inj_data : mdl_data;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_en"},   {31'd0, memory_enable}, 32'd0);
        check_val({tag, "_addr"}, {16'd0, memory_address}, 32'd0);
        check_val({tag, "_busy"}, {31'd0, fsm_busy}, 32'd0);
        check_val({tag, "_wda"},  {31'd0, write_data_array}, 32'd0);
        check_val({tag, "_idx"},  {29'd0, cache_word_index}, 32'd0);
        check_val({tag, "_data"}, {16'd0, cache_data}, 32'd0);
        check_val({tag, "_tag"},  {31'd0, write_tag_array}, 32'd0);
        check_val({tag, "_done"}, {31'd0, fill_done}, 32'd0);
    endtask

    // Called at a negedge; miss accepted at the next posedge (edge 0); returns at the negedge of cycle 13.
    task automatic fill_check(input logic [15:0] maddr, input bit noise);
        logic [15:0] base;
        logic [2:0]  mw;
        logic [2:0]  w;
        logic        exp_en;
        logic        exp_w;
        base = maddr & 16'hFFF0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        mw = maddr[3:1];
`else
        mw = 3'd0;
`endif
        miss_detected = 1'b1;
        miss_address  = maddr;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            exp_en = (c <= 8);
            exp_w  = (c >= 5) && (c <= 12);
            check_val("req_en", {31'd0, memory_enable}, {31'd0, exp_en});
            if (exp_en) begin
                w = mw + 3'(c - 1);
                check_val("req_addr", {16'd0, memory_address}, {16'd0, base + {12'd0, w, 1'b0}});
                obs_addr[c-1] = memory_address;
            end
            check_val("wr_data_strobe", {31'd0, write_data_array}, {31'd0, exp_w});
            if (exp_w) begin
                w = mw + 3'(c - 5);
                check_val("word_index", {29'd0, cache_word_index}, {29'd0, w});
                check_val("cache_data", {16'd0, cache_data}, {16'd0, mem_word(base + {12'd0, w, 1'b0})});
                obs_idx[c-5] = cache_word_index;
            end
            check_val("tag_write", {31'd0, write_tag_array}, {31'd0, c == 12});
            check_val("fill_done", {31'd0, fill_done}, {31'd0, c == 12});
            check_val("busy", {31'd0, fsm_busy}, {31'd0, c <= 12});
            if (c == 1) miss_detected = 1'b0;
            if (noise && c == 3) begin
                miss_detected = 1'b1;
                miss_address  = 16'h4000;
            end
            if (noise && c == 7) miss_detected = 1'b0;
        end
        $display("fill miss=%04h base=%04h first_word=%0d noise=%0d", maddr, base, mw, noise);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check_val("idle_busy", {31'd0, fsm_busy}, 32'd0);

        // Miss at 0x1236 with a competing miss during the fill, then 0x4000 accepted back to back.
        fill_check(16'h1236, 1'b1);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        check_val("addr0_1236", {16'd0, obs_addr[0]}, 32'h1236);
        check_val("addr7_1236", {16'd0, obs_addr[7]}, 32'h1234);
`else
        check_val("addr0_1236", {16'd0, obs_addr[0]}, 32'h1230);
        check_val("addr7_1236", {16'd0, obs_addr[7]}, 32'h123E);
`endif
        fill_check(16'h4000, 1'b0);
        check_val("addr0_4000", {16'd0, obs_addr[0]}, 32'h4000);

        // Stray return data while idle.
        inj_valid = 1'b1;
        inj_data  = 16'hBEEF;
        #1;
        check_val("idle_valid_wda",  {31'd0, write_data_array}, 32'd0);
        check_val("idle_valid_tag",  {31'd0, write_tag_array}, 32'd0);
        check_val("idle_valid_done", {31'd0, fill_done}, 32'd0);
        @(negedge clk);
        inj_valid = 1'b0;
        check_val("idle_valid_busy", {31'd0, fsm_busy}, 32'd0);
        $display("idle return 0xBEEF ignored");

        // Reset in cycle 7 of a fill.
        miss_detected = 1'b1;
        miss_address  = 16'h2468;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            miss_detected = 1'b0;
        end
        check_val("pre_reset_busy", {31'd0, fsm_busy}, 32'd1);
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_val("post_reset_busy", {31'd0, fsm_busy}, 32'd0);
            check_val("post_reset_tag",  {31'd0, write_tag_array}, 32'd0);
            check_val("post_reset_en",   {31'd0, memory_enable}, 32'd0);
        end
        $display("reset mid-fill abandoned miss=2468");
        fill_check(16'h0010, 1'b0);
        check_val("addr0_0010", {16'd0, obs_addr[0]}, 32'h0010);

        fill_check(16'h123A, 1'b0);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        check_val("addr0_123A", {16'd0, obs_addr[0]}, 32'h123A);
        check_val("addr3_123A", {16'd0, obs_addr[3]}, 32'h1230);
        check_val("idx0_123A",  {29'd0, obs_idx[0]}, 32'd5);
        check_val("idx3_123A",  {29'd0, obs_idx[3]}, 32'd0);
`else
        check_val("addr0_123A", {16'd0, obs_addr[0]}, 32'h1230);
        check_val("idx0_123A",  {29'd0, obs_idx[0]}, 32'd0);
`endif

        fill_check(16'hFFFE, 1'b0);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        check_val("addr0_FFFE", {16'd0, obs_addr[0]}, 32'hFFFE);
        check_val("addr1_FFFE", {16'd0, obs_addr[1]}, 32'hFFF0);
`else
        check_val("addr0_FFFE", {16'd0, obs_addr[0]}, 32'hFFF0);
        check_val("addr7_FFFE", {16'd0, obs_addr[7]}, 32'hFFFE);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
